// File: rtl/qs_partition_engine_if.sv
// Bundle of the sort-controller handshake and the single-port data RAM bus
// seen by the partition engine.
interface qs_partition_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              init_p;
  logic [ADDR_W-1:0] ret1;
  logic [ADDR_W-1:0] ret2;
  logic              complete;
  logic [ADDR_W-1:0] loc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Environment side: controller plus RAM.
  modport master (
    output init_p, ret1, ret2, mem_rdata,
    input  complete, loc, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  init_p, ret1, ret2, mem_rdata,
    output complete, loc, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/qs_partition_engine.sv
// In-place Lomuto partition of A[ret1..ret2] around pivot A[ret2] over a
// single-port synchronous RAM; returns the pivot's final index on loc.
module qs_partition_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  qs_partition_engine_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StPiv, StCmp, StSw1, StSw2, StNxt, StFrd, StFw1, StFw2, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] s_q, s_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] loc_q, loc_d;
  logic [DATA_W-1:0] pivot_q, pivot_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  logic [DATA_W-1:0] tmp2_q, tmp2_d;

  localparam logic [ADDR_W-1:0] One = ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hi_q    <= '0;
      s_q     <= '0;
      j_q     <= '0;
      loc_q   <= '0;
      pivot_q <= '0;
      tmp_q   <= '0;
      tmp2_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      s_q     <= s_d;
      j_q     <= j_d;
      loc_q   <= loc_d;
      pivot_q <= pivot_d;
      tmp_q   <= tmp_d;
      tmp2_q  <= tmp2_d;
    end
  end

  // Read addresses are driven combinationally so mem_rdata is valid in the
  // very next state.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    s_d           = s_q;
    j_d           = j_q;
    loc_d         = loc_q;
    pivot_d       = pivot_q;
    tmp_d         = tmp_q;
    tmp2_d        = tmp2_q;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.init_p) begin
          hi_d = bus.ret2;
          s_d  = bus.ret1;
          j_d  = bus.ret1;
          if (bus.ret1 >= bus.ret2) begin
            loc_d   = bus.ret1;
            state_d = StDone;
          end else begin
            bus.mem_addr = bus.ret2;
            state_d      = StPiv;
          end
        end
      end
      StPiv: begin
        pivot_d = bus.mem_rdata;
        if (j_q == hi_q) begin
          state_d = StFrd;
        end else begin
          bus.mem_addr = j_q;
          state_d      = StCmp;
        end
      end
      StCmp: begin
        tmp_d = bus.mem_rdata;
        if (bus.mem_rdata < pivot_q) begin
          if (s_q != j_q) begin
            bus.mem_addr = s_q;
            state_d      = StSw1;
          end else begin
            s_d     = s_q + One;
            j_d     = j_q + One;
            state_d = StNxt;
          end
        end else begin
          j_d     = j_q + One;
          state_d = StNxt;
        end
      end
      StSw1: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = s_q;
        bus.mem_wdata = tmp_q;
        tmp2_d        = bus.mem_rdata;
        state_d       = StSw2;
      end
      StSw2: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = j_q;
        bus.mem_wdata = tmp2_q;
        s_d           = s_q + One;
        j_d           = j_q + One;
        state_d       = StNxt;
      end
      StNxt: begin
        if (j_q == hi_q) begin
          state_d = StFrd;
        end else begin
          bus.mem_addr = j_q;
          state_d      = StCmp;
        end
      end
      StFrd: begin
        bus.mem_addr = s_q;
        state_d      = StFw1;
      end
      StFw1: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = hi_q;
        bus.mem_wdata = bus.mem_rdata;
        state_d       = StFw2;
      end
      StFw2: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = s_q;
        bus.mem_wdata = pivot_q;
        loc_d         = s_q;
        state_d       = StDone;
      end
      StDone: begin
        if (!bus.init_p) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.complete = (state_q == StDone);
  assign bus.loc      = loc_q;

endmodule
